// File: rtl/cordic_pkg.sv
// Shared constants and elaboration helpers for the pipelined CORDIC sin/cos engine.
// Tables are held at 32 fractional bits and rounded down to the instance width.
package cordic_pkg;

    localparam int GUARD     = 2;
    localparam int TABLE_LEN = 24;

    // CORDIC gain compensation 0.6072529350 at 32 fractional bits.
    localparam logic [31:0] K_Q32 = 32'h9B74_EDA8;

    // atan(2^-i) in binary-angle units where pi == 2^31.
    function automatic logic [31:0] atan_q32(input int idx);
        case (idx)
            0:       return 32'h2000_0000;
            1:       return 32'h12E4_051E;
            2:       return 32'h09FB_385B;
            3:       return 32'h0511_11D4;
            4:       return 32'h028B_0D43;
            5:       return 32'h0145_D7E1;
            6:       return 32'h00A2_F61E;
            7:       return 32'h0051_7C55;
            8:       return 32'h0028_BE53;
            9:       return 32'h0014_5F2F;
            10:      return 32'h000A_2F98;
            11:      return 32'h0005_17CC;
            12:      return 32'h0002_8BE6;
            13:      return 32'h0001_45F3;
            14:      return 32'h0000_A2FA;
            15:      return 32'h0000_517D;
            16:      return 32'h0000_28BE;
            17:      return 32'h0000_145F;
            18:      return 32'h0000_0A30;
            19:      return 32'h0000_0518;
            20:      return 32'h0000_028C;
            21:      return 32'h0000_0146;
            22:      return 32'h0000_00A3;
            23:      return 32'h0000_0051;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] atan_scaled(input int idx, input int width);
        logic [32:0] acc;
        acc = {1'b0, atan_q32(idx)};
        if (width < 32) begin
            acc = (acc + (33'd1 << (31 - width))) >> (32 - width);
        end
        return acc[31:0];
    endfunction

    // Gain constant with WIDTH fractional bits (the x/y internal format).
    function automatic logic [33:0] k_scaled(input int width);
        logic [33:0] acc;
        acc = {2'b00, K_Q32};
        if (width < 32) begin
            acc = (acc + (34'd1 << (31 - width))) >> (32 - width);
        end
        return acc;
    endfunction

    function automatic bit width_ok(input int width);
        return (width >= 12) && (width <= 32);
    endfunction

    function automatic bit stages_ok(input int stages, input int width);
        return (stages >= 8) && (stages <= width) && (stages <= TABLE_LEN);
    endfunction

endpackage

// File: rtl/cordic_sincos_pipe_if.sv
// Angle-in / sin-cos-out bus of the CORDIC engine; the master drives angles and
// the pipeline advance, the slave (the engine) returns qualified results.
interface cordic_sincos_pipe_if #(
    parameter int WIDTH = 22
);
    logic                    enable;
    logic                    valid_in;
    logic signed [WIDTH-1:0] angle_in;
    logic                    valid_out;
    logic signed [WIDTH-1:0] cos_out;
    logic signed [WIDTH-1:0] sin_out;

    modport master (
        output enable, valid_in, angle_in,
        input  valid_out, cos_out, sin_out
    );

    modport slave (
        input  enable, valid_in, angle_in,
        output valid_out, cos_out, sin_out
    );
endinterface

// File: rtl/cordic_stage.sv
// One registered CORDIC micro-rotation: rotate (x, y) by +/-atan(2^-SHIFT)
// toward z = 0, carrying the valid bit alongside the data.
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int                WIDTH = 22,
    parameter int                SHIFT = 0,
    parameter logic [WIDTH:0]    ATAN  = '0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          valid_i,
    input  logic signed [WIDTH+GUARD-1:0] x_i,
    input  logic signed [WIDTH+GUARD-1:0] y_i,
    input  logic signed [WIDTH:0]         z_i,
    output logic                          valid_o,
    output logic signed [WIDTH+GUARD-1:0] x_o,
    output logic signed [WIDTH+GUARD-1:0] y_o,
    output logic signed [WIDTH:0]         z_o
);
    localparam int XW = WIDTH + GUARD;

    logic                 valid_d, valid_q;
    logic signed [XW-1:0] x_d, x_q;
    logic signed [XW-1:0] y_d, y_q;
    logic signed [WIDTH:0] z_d, z_q;
    logic signed [WIDTH:0] atan_s;

    assign atan_s = $signed(ATAN);

    always_comb begin
        valid_d = valid_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        if (enable) begin
            valid_d = valid_i;
            // Negative residual angle: rotate clockwise to bring z back up.
            if (z_i[WIDTH]) begin
                x_d = x_i + (y_i >>> SHIFT);
                y_d = y_i - (x_i >>> SHIFT);
                z_d = z_i + atan_s;
            end else begin
                x_d = x_i - (y_i >>> SHIFT);
                y_d = y_i + (x_i >>> SHIFT);
                z_d = z_i - atan_s;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
        end else begin
            valid_q <= valid_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
        end
    end

    assign valid_o = valid_q;
    assign x_o     = x_q;
    assign y_o     = y_q;
    assign z_o     = z_q;

endmodule

// File: rtl/cordic_sincos_pipe.sv
// Fully pipelined CORDIC sin/cos: input register, STAGES micro-rotations, rounding
// output register. Define CORDIC_QUADRANT_EN for full-circle quadrant pre-rotation.
module cordic_sincos_pipe
    import cordic_pkg::*;
#(
    parameter int WIDTH  = 22,
    parameter int STAGES = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    cordic_sincos_pipe_if.slave   bus
);
    localparam int                   XW      = WIDTH + GUARD;
    localparam logic signed [XW-1:0] K_INT   = XW'(k_scaled(WIDTH));
    localparam logic signed [WIDTH:0] QUARTER = (WIDTH+1)'(1) << (WIDTH-2);

    generate
        if (!width_ok(WIDTH)) begin : g_bad_width
            $error("cordic_sincos_pipe: WIDTH must lie in 12..32");
        end
        if (!stages_ok(STAGES, WIDTH)) begin : g_bad_stages
            $error("cordic_sincos_pipe: STAGES must lie in 8..min(WIDTH,24)");
        end
    endgenerate

    logic                  v0_d, v0_q;
    logic signed [XW-1:0]  x0_d, x0_q;
    logic signed [XW-1:0]  y0_d, y0_q;
    logic signed [WIDTH:0] z0_d, z0_q;
    logic signed [WIDTH:0] angle_ext;

    assign angle_ext = {bus.angle_in[WIDTH-1], bus.angle_in};

    always_comb begin
        v0_d = v0_q;
        x0_d = x0_q;
        y0_d = y0_q;
        z0_d = z0_q;
        if (bus.enable) begin
            v0_d = bus.valid_in;
            x0_d = K_INT;
            y0_d = '0;
            z0_d = angle_ext;
`ifdef CORDIC_QUADRANT_EN
            // Fold the outer quadrants onto +/-pi/2 so the residual fits the CORDIC range.
            case (bus.angle_in[WIDTH-1:WIDTH-2])
                2'b01: begin
                    x0_d = '0;
                    y0_d = K_INT;
                    z0_d = angle_ext - QUARTER;
                end
                2'b10: begin
                    x0_d = '0;
                    y0_d = -K_INT;
                    z0_d = angle_ext + QUARTER;
                end
                default: ;
            endcase
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v0_q <= 1'b0;
            x0_q <= '0;
            y0_q <= '0;
            z0_q <= '0;
        end else begin
            v0_q <= v0_d;
            x0_q <= x0_d;
            y0_q <= y0_d;
            z0_q <= z0_d;
        end
    end

    // Element 0 is the input register; element gi+1 is the output of stage gi.
    logic                  v_pipe [0:STAGES];
    logic signed [XW-1:0]  x_pipe [0:STAGES];
    logic signed [XW-1:0]  y_pipe [0:STAGES];
    logic signed [WIDTH:0] z_pipe [0:STAGES];

    assign v_pipe[0] = v0_q;
    assign x_pipe[0] = x0_q;
    assign y_pipe[0] = y0_q;
    assign z_pipe[0] = z0_q;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            cordic_stage #(
                .WIDTH (WIDTH),
                .SHIFT (gi),
                .ATAN  ((WIDTH+1)'(atan_scaled(gi, WIDTH)))
            ) u_stage (
                .clk     (clk),
                .reset_n (reset_n),
                .enable  (bus.enable),
                .valid_i (v_pipe[gi]),
                .x_i     (x_pipe[gi]),
                .y_i     (y_pipe[gi]),
                .z_i     (z_pipe[gi]),
                .valid_o (v_pipe[gi+1]),
                .x_o     (x_pipe[gi+1]),
                .y_o     (y_pipe[gi+1]),
                .z_o     (z_pipe[gi+1])
            );
        end
    endgenerate

    logic                    vout_d, vout_q;
    logic signed [WIDTH-1:0] cos_d, cos_q;
    logic signed [WIDTH-1:0] sin_d, sin_q;
    logic signed [XW-1:0]    x_rnd, y_rnd;

    // Half-up rounding of the guard bits; |x|,|y| < 2 so the add cannot wrap.
    assign x_rnd = x_pipe[STAGES] + XW'(2);
    assign y_rnd = y_pipe[STAGES] + XW'(2);

    always_comb begin
        vout_d = vout_q;
        cos_d  = cos_q;
        sin_d  = sin_q;
        if (bus.enable) begin
            vout_d = v_pipe[STAGES];
            cos_d  = x_rnd[XW-1:GUARD];
            sin_d  = y_rnd[XW-1:GUARD];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vout_q <= 1'b0;
            cos_q  <= '0;
            sin_q  <= '0;
        end else begin
            vout_q <= vout_d;
            cos_q  <= cos_d;
            sin_q  <= sin_d;
        end
    end

    assign bus.valid_out = vout_q;
    assign bus.cos_out   = cos_q;
    assign bus.sin_out   = sin_q;

    logic unused_bits;
    assign unused_bits = ^{z_pipe[STAGES], x_rnd[GUARD-1:0], y_rnd[GUARD-1:0]};

endmodule

// File: doc/cordic_sincos_pipe.md
# cordic_sincos_pipe

Parametrised, fully pipelined CORDIC rotation engine producing cosine and sine of a binary-angle input. It succeeds the fixed 22-bit cosine-only pipeline. It adds configurable width and depth, a valid pipeline, pipeline stall, simultaneous sin/cos outputs and optional full-circle quadrant pre-rotation. It sits in the arithmetic datapath as a one-result-per-cycle function unit feeding the floating-point conversion stage.

## Interface
- WIDTH, 22: angle and output width in bits (12..32).
- STAGES, 16: number of micro-rotation stages (8..min(WIDTH,24)).
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  pipeline advance; low = every register holds
- valid_in  in  1  angle_in qualifies this cycle
- angle_in  in  WIDTH  signed binary angle: value·π/2^(WIDTH-1) rad, range [-π, π)
- valid_out  out  1  cos_out/sin_out qualify
- cos_out  out  WIDTH  signed Q2.(WIDTH-2) cosine
- sin_out  out  WIDTH  signed Q2.(WIDTH-2) sine

## Operation
- Internal format:
  - x/y: WIDTH+2 bits, two LSB guard bits, WIDTH fractional bits.
  - z: WIDTH+1 bits, binary-angle units, sign-extended.
- Stage 0 (input register), selected by the quadrant q = angle_in[WIDTH-1:WIDTH-2]:
  - q=00/11: x0=K, y0=0, z0=angle_in.
  - q=01: x0=0, y0=K, z0=angle_in−2^(WIDTH-2).
  - q=10: x0=0, y0=−K, z0=angle_in+2^(WIDTH-2).
- K = 0.6072529350 scaled to the internal format, round-to-nearest.
- Stage i (i=0..STAGES-1), with d = z sign bit:
  - d=0: x−=y>>>i, y+=x>>>i, z−=A[i].
  - d=1: x+=y>>>i, y−=x>>>i, z+=A[i].
  - Shifts are arithmetic.
  - A[i] = round(atan(2^-i)/π·2^(WIDTH-1)).
- Output register: x/y are rounded half-up to WIDTH bits by adding 2'b10, then dropping 2 LSBs. No saturation is needed, since |result| < 2.
- The valid bit travels alongside the data in every stage.
- Data registers load regardless of valid. Only valid_out qualifies the outputs.
- enable=0: all data and valid registers hold, and outputs remain stable. This includes valid_out, which stays asserted if it already was.
- Reset (async assert, any time): all data registers, cos_out, sin_out = 0; every valid bit and valid_out = 0. In-flight results are discarded.
- Deassertion of reset is synchronised externally. The first valid_in is accepted on the first enabled edge after release.

## Timing
- Latency: STAGES+2 enabled clock edges from valid_in sampled to valid_out (18 for defaults). Cycles with enable=0 do not count.
- Throughput: one angle per enabled cycle. There are no bubbles and no backpressure beyond enable.
- Accuracy: |error| ≤ 2^(WIDTH-STAGES) output LSB (64 LSB for defaults).
- Critical path: one (WIDTH+2)-bit add/sub per stage.

## Configuration
- CORDIC_QUADRANT_EN defined: stage-0 quadrant pre-rotation is as above, and the full [-π, π) input range is valid.
- CORDIC_QUADRANT_EN undefined: stage 0 always loads x0=K, y0=0, z0=angle_in.
  - Valid inputs are limited to [-π/2, π/2).
  - Outputs for other inputs are unspecified, but valid_out timing is unchanged.

## Structure
- Package cordic_pkg holds:
  - the atan table as a 24-entry constant at 32 fractional binary-angle bits, right-shifted with rounding to WIDTH at elaboration;
  - the K constant at 32 fractional bits;
  - the GUARD=2 localparam;
  - range-check functions for WIDTH/STAGES.
- Sub-module cordic_stage is one registered micro-rotation, parametrised by WIDTH, SHIFT and ATAN. The top instantiates it STAGES times via generate. The stage-0 and output registers stay in the top.

## Test plan
Defaults throughout (WIDTH=22, STAGES=16, macro defined); "±64" means within 64 output LSB.
1. angle_in=0, valid_in pulse → 18 cycles later valid_out=1, cos_out=1048576±64, sin_out=0±64.
2. angle_in=2^19 (π/4) → cos_out and sin_out both 741455±64.
3. Quadrant inputs:
   - angle_in=−2^21 (−π) → cos_out=−1048576±64, sin_out=0±64.
   - angle_in=3·2^19 (3π/4) → cos_out=−741455±64, sin_out=741455±64.
4. 100 back-to-back random angles with valid every cycle → 100 consecutive valid_out, order preserved, each within ±64 of a double-precision model.
5. Stall: enable low for 5 cycles mid-stream → outputs frozen, latency extends by exactly 5, no results lost or duplicated.
6. reset_n pulsed low asynchronously with 10 results in flight → valid_out=0 and cos_out=sin_out=0 immediately; no stale valid_out after release.
